// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_col chain head sequencer.
//   state_e    : sequencer FSM states
//   tag_e      : slot tag carried alongside an outstanding memory read
//   INST_*     : instruction encodings consumed by column 0 (i_inst)
//   PAD_SLOTS  : number of leading padding slots in a load burst
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARST,
    ST_LOAD,
    ST_EXEC,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_PAD,
    TAG_LOAD,
    TAG_EXEC
  } tag_e;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int PAD_SLOTS = 2;

  // Padding slots still present a load instruction, just with zero data.
  function automatic logic [1:0] tag_to_inst(input tag_e t);
    case (t)
      TAG_PAD, TAG_LOAD: return INST_LOAD;
      TAG_EXEC:          return INST_EXEC;
      default:           return INST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Bundle of the sequencer's controller handshake, vector-memory read port and
// column-0 feed.
//   master : the sequencer (drives mem_rd/mem_addr, inst/q_out, arr_rst,
//            busy/done; receives job inputs and mem_data)
//   slave  : the surrounding controller + memory + column chain
interface mac_seq_if #(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int addr_bw = 6
) ();

  logic                  start;
  logic                  load_en;
  logic [addr_bw-1:0]    n_query;
  logic [addr_bw-1:0]    key_base;
  logic [addr_bw-1:0]    q_base;
  logic                  mem_rd;
  logic [addr_bw-1:0]    mem_addr;
  logic [pr*bw-1:0]      mem_data;
  logic [1:0]            inst;
  logic [pr*bw-1:0]      q_out;
  logic                  arr_rst;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, load_en, n_query, key_base, q_base, mem_data,
    output mem_rd, mem_addr, inst, q_out, arr_rst, busy, done
  );

  modport slave (
    output start, load_en, n_query, key_base, q_base, mem_data,
    input  mem_rd, mem_addr, inst, q_out, arr_rst, busy, done
  );

endinterface

// File: rtl/mac_rd_align.sv
// Read-alignment stage: carries the slot tag issued with a memory read one
// cycle so it meets the returning data, then registers inst/q_out together.
//   clk, reset  : clock, async active-low reset
//   tag_i       : tag of the slot issued this cycle
//   mem_data_i  : memory read data (valid the cycle after the read)
//   inst_o      : aligned instruction for column 0
//   q_out_o     : aligned operand for column 0 (zero for pad/idle slots)
module mac_rd_align
  import mac_pkg::*;
#(
  parameter int bw = 8,
  parameter int pr = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  tag_e             tag_i,
  input  logic [pr*bw-1:0] mem_data_i,
  output logic [1:0]       inst_o,
  output logic [pr*bw-1:0] q_out_o
);

  tag_e             tag_q;
  logic [1:0]       inst_d, inst_q;
  logic [pr*bw-1:0] q_d, q_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    inst_d = tag_to_inst(tag_q);
    q_d    = '0;
    if (tag_q == TAG_LOAD || tag_q == TAG_EXEC) q_d = mem_data_i;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q  <= TAG_NONE;
      inst_q <= INST_IDLE;
      q_q    <= '0;
    end else begin
      tag_q  <= tag_i;
      inst_q <= inst_d;
      q_q    <= q_d;
    end
  end

  assign inst_o  = inst_q;
  assign q_out_o = q_q;

endmodule

// File: rtl/mac_seq.sv
// Head-of-chain sequencer for mac_col: array reset, key load burst, query
// execute stream, pipeline drain, then a done pulse.
//   clk, reset : clock, async active-low reset
//   bus        : mac_seq_if.master (job handshake, memory read port, column feed)
// Parameters: bw/pr element width and count, col chain length, addr_bw memory
// address width, drain idle cycles after the last instruction (>= col+4).
module mac_seq
  import mac_pkg::*;
#(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int col     = 8,
  parameter int addr_bw = 6,
  parameter int drain   = 12
) (
  input logic       clk,
  input logic       reset,
  mac_seq_if.master bus
);

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [addr_bw-1:0] addr_t;

  localparam cnt_t PAD_CNT    = cnt_t'(PAD_SLOTS);
  localparam cnt_t LOAD_LAST  = cnt_t'(col + PAD_SLOTS - 1);
  // Drain counts from the cycle after the last issue, two cycles before the
  // last instruction reaches column 0, hence the +1.
  localparam cnt_t DRAIN_LAST = cnt_t'(drain + 1);

  state_e state_q;
  cnt_t   cnt_q;
  addr_t  nq_q, kb_q, qb_q;
  logic   mem_rd_q;
  addr_t  mem_addr_q;
  tag_e   tag_q;
  logic   arr_rst_q, busy_q, done_q;

  cnt_t   cnt_inc;
  logic   exec_last;

  assign cnt_inc   = cnt_q + 1'b1;
  assign exec_last = (cnt_inc == cnt_t'(nq_q));

  // Issue registers (mem_rd_q/mem_addr_q/tag_q) describe the slot issued in the
  // current cycle, so each transition loads the slot that follows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nq_q       <= '0;
      kb_q       <= '0;
      qb_q       <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      tag_q      <= TAG_NONE;
      arr_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      tag_q      <= TAG_NONE;
      arr_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            nq_q   <= bus.n_query;
            kb_q   <= bus.key_base;
            qb_q   <= bus.q_base;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (bus.load_en) begin
              state_q   <= ST_ARST;
              arr_rst_q <= 1'b1;
            end else if (bus.n_query != '0) begin
              state_q    <= ST_EXEC;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= bus.q_base;
              tag_q      <= TAG_EXEC;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_ARST: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
          tag_q   <= TAG_PAD;
        end
        ST_LOAD: begin
          if (cnt_q != LOAD_LAST) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= PAD_CNT) begin
              // Keys go out in reverse so key k settles in column k.
              mem_rd_q   <= 1'b1;
              mem_addr_q <= kb_q + addr_t'(LOAD_LAST - cnt_inc);
              tag_q      <= TAG_LOAD;
            end else begin
              tag_q <= TAG_PAD;
            end
          end else if (nq_q != '0) begin
            state_q    <= ST_EXEC;
            cnt_q      <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= qb_q;
            tag_q      <= TAG_EXEC;
          end else begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end
        end
        ST_EXEC: begin
          if (!exec_last) begin
            cnt_q      <= cnt_inc;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= qb_q + addr_t'(cnt_inc);
            tag_q      <= TAG_EXEC;
          end else begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mac_rd_align #(.bw(bw), .pr(pr)) u_align (
    .clk        (clk),
    .reset      (reset),
    .tag_i      (tag_q),
    .mem_data_i (bus.mem_data),
    .inst_o     (bus.inst),
    .q_out_o    (bus.q_out)
  );

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.arr_rst  = arr_rst_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mac_seq.sv
module tb_mac_seq;
  import mac_pkg::*;

  localparam int BW = 8, PR = 8, COL = 8, AW = 6, DRAIN = 12;
  localparam int DEPTH = 1 << AW;
  localparam int PAD = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_seq_if #(.bw(BW), .pr(PR), .addr_bw(AW)) bus ();

  mac_seq #(.bw(BW), .pr(PR), .col(COL), .addr_bw(AW), .drain(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One-cycle-latency vector memory.
  logic [PR*BW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: what column 0 should see, slot by slot ----------
  function automatic int n_slots(input logic ld, input int nq);
    return (ld ? COL + PAD : 0) + nq;
  endfunction

  // Cycle (counted from the cycle after start is sampled = 1) of the first inst.
  function automatic int first_cycle(input logic ld);
    return ld ? 4 : 3;
  endfunction

  function automatic int done_cycle(input logic ld, input int nq);
    int n;
    n = n_slots(ld, nq);
    return (n == 0) ? 1 : first_cycle(ld) + n + DRAIN;
  endfunction

  function automatic logic slot_is_pad(input logic ld, input int i);
    return ld && i < PAD;
  endfunction

  function automatic int slot_addr(input logic ld, input int kb, input int qb, input int i);
    int nload;
    nload = ld ? COL + PAD : 0;
    if (i < nload) return (kb + COL + 1 - i) % DEPTH;
    return (qb + i - nload) % DEPTH;
  endfunction

  function automatic logic [1:0] slot_inst(input logic ld, input int i);
    return (ld && i < COL + PAD) ? INST_LOAD : INST_EXEC;
  endfunction

  function automatic logic [127:0] sample();
    return {58'd0, bus.inst, bus.mem_rd, bus.arr_rst, bus.busy, bus.done, bus.q_out};
  endfunction

  // ---- run one job and compare every cycle to the model -------------------
  task automatic run_job(input int jid, input logic ld, input int nq, input int kb,
                         input int qb, input int exp_n, input int exp_done, input logic poke);
    int n, first, dk, seen_n, seen_done, ri, si;
    logic [1:0]       e_inst;
    logic             e_rd;
    logic [PR*BW-1:0] e_q;
    logic [PR*BW-1:0] ldq [COL+PAD];
    n     = n_slots(ld, nq);
    first = first_cycle(ld);
    dk    = done_cycle(ld, nq);
    for (int i = 0; i < COL + PAD; i++) ldq[i] = '0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.load_en  = ld;
    bus.n_query  = AW'(nq);
    bus.key_base = AW'(kb);
    bus.q_base   = AW'(qb);
    @(negedge clk);
    bus.start    = 1'b0;
    // Scramble job inputs: the DUT must use its latched copies.
    bus.load_en  = 1'($urandom);
    bus.n_query  = AW'($urandom);
    bus.key_base = AW'($urandom);
    bus.q_base   = AW'($urandom);
    seen_n = 0;
    seen_done = -1;
    for (int k = 1; k <= dk + 2; k++) begin
      si = k - first;
      ri = k - first + PAD;
      e_inst = INST_IDLE;
      e_q    = '0;
      if (si >= 0 && si < n) begin
        e_inst = slot_inst(ld, si);
        if (!slot_is_pad(ld, si)) e_q = mem[slot_addr(ld, kb, qb, si)];
      end
      e_rd = (ri >= 0 && ri < n && !slot_is_pad(ld, ri));
      check($sformatf("job%0d k=%0d {inst,rd,arst,busy,done,q}", jid, k), sample(),
            {58'd0, e_inst, e_rd, ld && k == 1, k <= dk, k == dk, e_q});
      if (e_rd)
        check($sformatf("job%0d k=%0d mem_addr", jid, k), 128'(bus.mem_addr),
              128'(slot_addr(ld, kb, qb, ri)));
      if (bus.inst != INST_IDLE) seen_n++;
      if (bus.done && seen_done < 0) seen_done = k;
      if (ld && si >= 0 && si < COL + PAD) ldq[si] = bus.q_out;
      bus.start = poke && k == 5;
      if (poke && k == 5) bus.load_en = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check($sformatf("job%0d inst_cycles", jid), 128'(seen_n), 128'(exp_n));
    check($sformatf("job%0d done_cycle", jid), 128'(seen_done), 128'(exp_done));
    // Column k of the chain latches load slot col+1-k and must hold key k.
    if (ld)
      for (int c = 0; c < COL; c++)
        check($sformatf("job%0d col%0d_key", jid, c), 128'(ldq[COL + 1 - c]),
              128'(mem[(kb + c) % DEPTH]));
  endtask

  typedef struct {
    logic ld;
    int   nq;
    int   kb;
    int   qb;
    int   exp_n;
    int   exp_done;
    logic poke;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int ld, nq;
    tbl[0] = '{1'b1, 0, 0,  0,  10, 26, 1'b0};  // load only
    tbl[1] = '{1'b1, 4, 0,  16, 14, 30, 1'b1};  // load+exec, start poked while busy
    tbl[2] = '{1'b0, 3, 0,  16, 3,  18, 1'b0};  // exec only
    tbl[3] = '{1'b0, 0, 0,  0,  0,  1,  1'b0};  // empty job
    tbl[4] = '{1'b1, 4, 60, 62, 14, 30, 1'b0};  // re-key, addresses wrap

    for (int a = 0; a < DEPTH; a++) mem[a] = {PR{8'(a + 1)}};
    bus.mem_data = '0;
    bus.start    = 1'b0;
    bus.load_en  = 1'b0;
    bus.n_query  = '0;
    bus.key_base = '0;
    bus.q_base   = '0;
    reset = 1'b0;
    #1;
    check("reset_state", {sample(), 6'(bus.mem_addr)}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int t = 0; t < 5; t++)
      run_job(t, tbl[t].ld, tbl[t].nq, tbl[t].kb, tbl[t].qb,
              tbl[t].exp_n, tbl[t].exp_done, tbl[t].poke);

    for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom};
    for (int t = 0; t < 6; t++) begin
      ld = int'($urandom_range(0, 1));
      nq = int'($urandom_range(0, 9));
      run_job(10 + t, 1'(ld), nq, int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, DEPTH - 1)), n_slots(1'(ld), nq),
              done_cycle(1'(ld), nq), 1'b0);
    end

    // Asynchronous reset in the middle of the execute stream.
    @(negedge clk);
    bus.start = 1'b1; bus.load_en = 1'b1; bus.n_query = AW'(6);
    bus.key_base = '0; bus.q_base = AW'(16);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_exec_inst", 128'(bus.inst), 128'(INST_EXEC));
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", {sample(), 6'(bus.mem_addr)}, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("held_reset_%0d", k), {sample(), 6'(bus.mem_addr)}, '0);
    end
    reset = 1'b1;
    run_job(20, 1'b1, 2, 5, 40, 12, 28, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
